// File: rtl/cpu_int_ctrl_pkg.sv
// Shared types and constants for the NES CPU interrupt controller.
package cpu_int_ctrl_pkg;

  // Kind of interrupt most recently acknowledged by the core.
  typedef enum logic [1:0] {
    INT_NONE = 2'd0,
    INT_NMI  = 2'd1,
    INT_IRQ  = 2'd2
  } int_type_e;

  // Request/acknowledge sequencing towards the 6502 core.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StNmiReq  = 2'd1,
    StIrqReq  = 2'd2,
    StService = 2'd3
  } ic_state_e;

  // Register port addresses.
  localparam logic [1:0] RegMask    = 2'd0;
  localparam logic [1:0] RegPending = 2'd1;
  localparam logic [1:0] RegSrcId   = 2'd2;
  localparam logic [1:0] RegNmiClr  = 2'd3;

endpackage

// File: rtl/cpu_int_ctrl_if.sv
// Core handshake and register bus between the 6502 side and the interrupt controller.
interface cpu_int_ctrl_if;
  import cpu_int_ctrl_pkg::*;

  logic        i_flag;
  logic        int_ack;
  logic        nmi;
  logic        irq;
  int_type_e   int_type;
  logic [2:0]  src_id;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;

  // Core / bus master side.
  modport master (
    output i_flag, int_ack, reg_we, reg_addr, reg_wdata,
    input  nmi, irq, int_type, src_id, reg_rdata
  );

  // Interrupt controller side.
  modport slave (
    input  i_flag, int_ack, reg_we, reg_addr, reg_wdata,
    output nmi, irq, int_type, src_id, reg_rdata
  );

endinterface

// File: rtl/cpu_int_ctrl_int_sync.sv
// Multi-flop synchroniser with a registered rising-edge detector on its output.
module cpu_int_ctrl_int_sync #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q,
  output logic [Width-1:0] rise
);

  logic [Width-1:0] stage_q [Stages];
  logic [Width-1:0] prev_q;

  // Shift chain plus one delayed copy of the synchronised value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Stages; i++) stage_q[i] <= '0;
      prev_q <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < Stages; i++) stage_q[i] <= stage_q[i-1];
      prev_q <= stage_q[Stages-1];
    end
  end

  assign q    = stage_q[Stages-1];
  assign rise = q & ~prev_q;

endmodule

// File: rtl/cpu_int_ctrl.sv
// Interrupt controller between NES peripherals and the 6502 core.
// Optional macro INT_ROTATE_PRIORITY_EN selects round-robin IRQ arbitration;
// without it the lowest-index pending source always wins.
module cpu_int_ctrl
  import cpu_int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  RST_MASK    = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               nmi_src,
  input  logic [NUM_IRQ-1:0] irq_src,
  cpu_int_ctrl_if.slave      bus
);

  ic_state_e    state_q;
  logic         nmi_q, irq_q;
  int_type_e    int_type_q;
  logic [2:0]   src_id_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic         nmi_latch_q;

  logic               nmi_sync, nmi_rise;
  logic [NUM_IRQ-1:0] irq_sync, irq_rise;
  logic [NUM_IRQ-1:0] pend, rot;
  logic               irq_req, nmi_pend;
  logic [2:0]         winner;
  logic               ack_nmi, ack_irq, clr_write, mask_write;
  logic [7:0]         rdata;

  cpu_int_ctrl_int_sync #(.Width(1), .Stages(SYNC_STAGES)) u_nmi_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (nmi_src),
    .q    (nmi_sync),
    .rise (nmi_rise)
  );

  cpu_int_ctrl_int_sync #(.Width(NUM_IRQ), .Stages(SYNC_STAGES)) u_irq_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (irq_src),
    .q    (irq_sync),
    .rise (irq_rise)
  );

  logic unused_ok;
  assign unused_ok = ^{nmi_sync, irq_rise, bus.reg_wdata};

  assign pend     = irq_sync & mask_q;
  assign irq_req  = (|pend) & ~bus.i_flag;
  // A fresh edge counts in the same cycle the latch sets, so NMI beats a coincident IRQ.
  assign nmi_pend = nmi_latch_q | nmi_rise;

  assign ack_nmi    = !stall && (state_q == StNmiReq) && bus.int_ack;
  assign ack_irq    = !stall && (state_q == StIrqReq) && bus.int_ack;
  assign clr_write  = !stall && bus.reg_we && (bus.reg_addr == RegNmiClr) && bus.reg_wdata[0];
  assign mask_write = !stall && bus.reg_we && (bus.reg_addr == RegMask);

`ifdef INT_ROTATE_PRIORITY_EN
  logic [2:0]           ptr_q;
  logic [2*NUM_IRQ-1:0] pend2;
  assign pend2 = {pend, pend} >> ptr_q;
  assign rot   = pend2[NUM_IRQ-1:0];

  // Round-robin pointer: search restarts just past the last serviced source.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 3'd0;
    end else if (ack_irq) begin
      ptr_q <= (winner == 3'(NUM_IRQ-1)) ? 3'd0 : winner + 3'd1;
    end
  end
`else
  logic [2:0] ptr_q;
  assign ptr_q = 3'd0;
  assign rot   = pend;
`endif

  // Lowest set bit of the (possibly rotated) pending vector, mapped back to a source index.
  always_comb begin
    int off;
    int sum;
    off = 0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    sum = off + int'(ptr_q);
    if (sum >= int'(NUM_IRQ)) sum = sum - int'(NUM_IRQ);
    winner = 3'(sum);
  end

  // NMI latch: a new edge always wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nmi_latch_q <= 1'b0;
    end else if (nmi_rise) begin
      nmi_latch_q <= 1'b1;
    end else if (ack_nmi || clr_write) begin
      nmi_latch_q <= 1'b0;
    end
  end

  // IRQ mask register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= RST_MASK[NUM_IRQ-1:0];
    end else if (mask_write) begin
      mask_q <= bus.reg_wdata[NUM_IRQ-1:0];
    end
  end

  // Request FSM with registered core-facing outputs; frozen while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      nmi_q      <= 1'b0;
      irq_q      <= 1'b0;
      int_type_q <= INT_NONE;
      src_id_q   <= 3'd0;
    end else if (!stall) begin
      case (state_q)
        StIdle: begin
          if (nmi_pend) begin
            state_q <= StNmiReq;
            nmi_q   <= 1'b1;
          end else if (irq_req) begin
            state_q <= StIrqReq;
            irq_q   <= 1'b1;
          end
        end
        StNmiReq: begin
          if (bus.int_ack) begin
            state_q    <= StService;
            nmi_q      <= 1'b0;
            int_type_q <= INT_NMI;
          end
        end
        StIrqReq: begin
          // Once the core has committed to the IRQ vector, finish that one first.
          if (bus.int_ack) begin
            state_q    <= StService;
            irq_q      <= 1'b0;
            int_type_q <= INT_IRQ;
            src_id_q   <= winner;
          end else if (nmi_pend) begin
            state_q <= StNmiReq;
            irq_q   <= 1'b0;
            nmi_q   <= 1'b1;
          end else if (!irq_req) begin
            state_q <= StIdle;
            irq_q   <= 1'b0;
          end
        end
        StService: begin
          state_q <= StIdle;
          nmi_q   <= 1'b0;
          irq_q   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Combinational register read mux.
  always_comb begin
    rdata = 8'h00;
    case (bus.reg_addr)
      RegMask: begin
        for (int i = 0; i < NUM_IRQ; i++) rdata[i] = mask_q[i];
      end
      RegPending: begin
        for (int i = 0; i < NUM_IRQ; i++) rdata[i] = pend[i];
        if (NUM_IRQ < 8) rdata[7] = nmi_latch_q;
      end
      RegSrcId: rdata[2:0] = src_id_q;
      default: rdata = 8'h00;
    endcase
  end

  assign bus.reg_rdata = rdata;
  assign bus.nmi       = nmi_q;
  assign bus.irq       = irq_q;
  assign bus.int_type  = int_type_q;
  assign bus.src_id    = src_id_q;

endmodule

// File: tb/tb_cpu_int_ctrl.sv
// Self-checking bench for cpu_int_ctrl; acknowledged interrupts are scoreboarded.
module tb_cpu_int_ctrl;
  import cpu_int_ctrl_pkg::*;

  localparam int unsigned NI = 4;
  localparam int unsigned SS = 2;

  typedef struct packed {
    int_type_e  t;
    logic [2:0] id;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall = 1'b0;
  logic          nmi_src = 1'b0;
  logic [NI-1:0] irq_src = '0;
  int            n_checks = 0;
  int            n_fail = 0;
  exp_t          sb[$];
  exp_t          e;

  cpu_int_ctrl_if bus ();

  cpu_int_ctrl #(.NUM_IRQ(NI), .SYNC_STAGES(SS), .RST_MASK(8'hFF)) dut (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .nmi_src (nmi_src),
    .irq_src (irq_src),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges with the given IRQ sources, release just after an edge.
  task automatic apply_reset(input logic [NI-1:0] src);
    rst = 1'b0; stall = 1'b0; nmi_src = 1'b0; irq_src = src;
    bus.i_flag = 1'b0; bus.int_ack = 1'b0; bus.reg_we = 1'b0;
    bus.reg_addr = RegMask; bus.reg_wdata = 8'h00;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(4'b0010);
    rst = 1'b0;
    #1;
    n_checks++; if (bus.nmi !== 1'b0) begin n_fail++; $display("FAIL rst_nmi got %0b want 0", bus.nmi); end
    n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got %0b want 0", bus.irq); end
    n_checks++; if (bus.int_type !== INT_NONE) begin n_fail++; $display("FAIL rst_type got %0d want 0", bus.int_type); end
    n_checks++; if (bus.src_id !== 3'd0) begin n_fail++; $display("FAIL rst_src got %0d want 0", bus.src_id); end
    bus.reg_addr = RegMask; #1;
    n_checks++; if (bus.reg_rdata !== 8'h0F) begin n_fail++; $display("FAIL rst_mask got %h want 0f", bus.reg_rdata); end
    tick();
    rst = 1'b1;
    for (int c = 1; c <= SS + 1; c++) begin
      tick();
      n_checks++;
      if (bus.irq !== (c == SS + 1)) begin
        n_fail++; $display("FAIL irq_latency edge %0d got %0b want %0b", c, bus.irq, (c == SS + 1));
      end
    end
    bus.int_ack = 1'b1; sb.push_back('{INT_IRQ, 3'd1});
    tick();
    bus.int_ack = 1'b0;
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL irq_ack scoreboard empty"); end
    else begin
      e = sb.pop_front();
      if (bus.int_type !== e.t || bus.src_id !== e.id) begin
        n_fail++; $display("FAIL irq_ack got type %0d id %0d want type %0d id %0d", bus.int_type, bus.src_id, e.t, e.id);
      end
    end
    n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_ack got %0b want 0", bus.irq); end
  endtask

  task automatic test_nmi_over_irq();
    apply_reset('0);
    tick(); tick(); tick();
    nmi_src = 1'b1; irq_src = 4'b0001;
    for (int c = 1; c <= SS + 1; c++) begin
      tick();
      n_checks++;
      if (bus.nmi !== (c == SS + 1) || bus.irq !== 1'b0) begin
        n_fail++; $display("FAIL nmi_first edge %0d got nmi %0b irq %0b want nmi %0b irq 0", c, bus.nmi, bus.irq, (c == SS + 1));
      end
    end
    bus.reg_addr = RegPending; #1;
    n_checks++; if (bus.reg_rdata !== 8'h81) begin n_fail++; $display("FAIL pend_nmi_irq got %h want 81", bus.reg_rdata); end
    bus.int_ack = 1'b1; sb.push_back('{INT_NMI, 3'd0});
    tick();
    bus.int_ack = 1'b0;
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL nmi_ack scoreboard empty"); end
    else begin
      e = sb.pop_front();
      if (bus.int_type !== e.t || bus.src_id !== e.id || bus.nmi !== 1'b0) begin
        n_fail++; $display("FAIL nmi_ack got type %0d id %0d nmi %0b want type %0d id %0d nmi 0", bus.int_type, bus.src_id, bus.nmi, e.t, e.id);
      end
    end
    n_checks++; if (bus.reg_rdata !== 8'h01) begin n_fail++; $display("FAIL nmi_latch_clr got %h want 01", bus.reg_rdata); end
    tick();
    n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL service_gap got %0b want 0", bus.irq); end
    tick();
    n_checks++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_nmi got %0b want 1", bus.irq); end
    bus.int_ack = 1'b1; sb.push_back('{INT_IRQ, 3'd0});
    tick();
    bus.int_ack = 1'b0;
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL irq0_ack scoreboard empty"); end
    else begin
      e = sb.pop_front();
      if (bus.int_type !== e.t || bus.src_id !== e.id) begin
        n_fail++; $display("FAIL irq0_ack got type %0d id %0d want type %0d id %0d", bus.int_type, bus.src_id, e.t, e.id);
      end
    end
  endtask

  task automatic test_mask_write();
    apply_reset(4'b0100);
    for (int c = 0; c < 10 && bus.irq !== 1'b1; c++) tick();
    n_checks++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL mask_req got %0b want 1", bus.irq); end
    bus.reg_we = 1'b1; bus.reg_addr = RegMask; bus.reg_wdata = 8'h0B;
    tick();
    bus.reg_we = 1'b0;
    n_checks++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL mask_write_edge got %0b want 1", bus.irq); end
    tick();
    n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL mask_drop got %0b want 0", bus.irq); end
    bus.reg_addr = RegPending; #1;
    n_checks++; if (bus.reg_rdata !== 8'h00) begin n_fail++; $display("FAIL mask_pend got %h want 00", bus.reg_rdata); end
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    n_checks++;
    if (bus.int_type !== INT_NONE || bus.irq !== 1'b0) begin
      n_fail++; $display("FAIL stray_ack got type %0d irq %0b want type 0 irq 0", bus.int_type, bus.irq);
    end
    stall = 1'b1; bus.reg_we = 1'b1; bus.reg_addr = RegMask; bus.reg_wdata = 8'h0F;
    tick();
    stall = 1'b0; bus.reg_we = 1'b0; #1;
    n_checks++; if (bus.reg_rdata !== 8'h0B) begin n_fail++; $display("FAIL stall_write got %h want 0b", bus.reg_rdata); end
  endtask

  task automatic test_stall_nmi();
    apply_reset('0);
    tick(); tick();
    stall = 1'b1; nmi_src = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) nmi_src = 1'b0;
      tick();
      n_checks++; if (bus.nmi !== 1'b0) begin n_fail++; $display("FAIL stall_nmi cycle %0d got %0b want 0", c, bus.nmi); end
    end
    bus.reg_addr = RegPending; #1;
    n_checks++; if (bus.reg_rdata !== 8'h80) begin n_fail++; $display("FAIL stall_pend got %h want 80", bus.reg_rdata); end
    stall = 1'b0;
    for (int c = 0; c < 2 && bus.nmi !== 1'b1; c++) tick();
    n_checks++; if (bus.nmi !== 1'b1) begin n_fail++; $display("FAIL nmi_after_stall got %0b want 1", bus.nmi); end
    bus.int_ack = 1'b1; sb.push_back('{INT_NMI, 3'd0});
    tick();
    bus.int_ack = 1'b0;
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL stall_ack scoreboard empty"); end
    else begin
      e = sb.pop_front();
      if (bus.int_type !== e.t || bus.src_id !== e.id) begin
        n_fail++; $display("FAIL stall_ack got type %0d id %0d want type %0d id %0d", bus.int_type, bus.src_id, e.t, e.id);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset(4'b1111);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 10 && bus.irq !== 1'b1; c++) tick();
      n_checks++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL b2b_req %0d got %0b want 1", k, bus.irq); end
      bus.int_ack = 1'b1;
`ifdef INT_ROTATE_PRIORITY_EN
      sb.push_back('{INT_IRQ, 3'(k)});
`else
      sb.push_back('{INT_IRQ, 3'd0});
`endif
      tick();
      bus.int_ack = 1'b0;
      n_checks++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_ack scoreboard empty"); end
      else begin
        e = sb.pop_front();
        if (bus.int_type !== e.t || bus.src_id !== e.id) begin
          n_fail++; $display("FAIL b2b_ack %0d got type %0d id %0d want type %0d id %0d", k, bus.int_type, bus.src_id, e.t, e.id);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset(4'b0001);
    bus.reg_we = 1'b1; bus.reg_addr = RegMask; bus.reg_wdata = 8'h03;
    tick();
    bus.reg_we = 1'b0;
    for (int c = 0; c < 10 && bus.irq !== 1'b1; c++) tick();
    n_checks++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL ar_req got %0b want 1", bus.irq); end
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL ar_irq got %0b want 0", bus.irq); end
    n_checks++; if (bus.reg_rdata !== 8'h0F) begin n_fail++; $display("FAIL ar_mask got %h want 0f", bus.reg_rdata); end
    tick();
    rst = 1'b1;
  endtask

  initial begin
    bus.i_flag = 1'b0; bus.int_ack = 1'b0; bus.reg_we = 1'b0;
    bus.reg_addr = RegMask; bus.reg_wdata = 8'h00;
    test_reset();
    test_nmi_over_irq();
    test_mask_write();
    test_stall_nmi();
    test_back_to_back();
    test_async_reset();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
